// File: rtl/shift_unit_ctrl.sv
// Multicycle sequencer for the shift datapath: steps LOAD -> SHIFT -> WB per accepted op
// and drives the shift-amount mux, shifter data-source select and shifter command.
module shift_unit_ctrl #(
    parameter int CMD_W = 3,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             flush,
    output logic [SEL_W-1:0] amt_sel,
    output logic             data_sel,
    output logic [CMD_W-1:0] shift_cmd,
    output logic             busy,
    output logic             done,
    output logic             reg_wr,
    output logic             err
);

    localparam logic [2:0] OP_SLL     = 3'b000;
    localparam logic [2:0] OP_SRL     = 3'b001;
    localparam logic [2:0] OP_SRA     = 3'b010;
    localparam logic [2:0] OP_SLLV    = 3'b011;
    localparam logic [2:0] OP_SRLV    = 3'b100;
    localparam logic [2:0] OP_SRAV    = 3'b101;
    localparam logic [2:0] OP_LUI     = 3'b110;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    localparam logic [SEL_W-1:0] AMT_SHAMT   = SEL_W'(3'b000);
    localparam logic [SEL_W-1:0] AMT_REGB    = SEL_W'(3'b010);
    localparam logic [SEL_W-1:0] AMT_CONST16 = SEL_W'(3'b100);

    localparam logic [CMD_W-1:0] CMD_NOP   = CMD_W'(3'b000);
    localparam logic [CMD_W-1:0] CMD_LOAD  = CMD_W'(3'b001);
    localparam logic [CMD_W-1:0] CMD_SLEFT = CMD_W'(3'b010);
    localparam logic [CMD_W-1:0] CMD_SRL   = CMD_W'(3'b011);
    localparam logic [CMD_W-1:0] CMD_SRA   = CMD_W'(3'b100);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        WB
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [2:0]       opLatched;
    logic [2:0]       opNext;
    logic [SEL_W-1:0] amtSelNext;
    logic             dataSelNext;
    logic [CMD_W-1:0] shiftCmdNext;
    logic             busyNext;
    logic             doneNext;
    logic             regWrNext;
    logic             errNext;

    function automatic logic [SEL_W-1:0] amtSelFor(input logic [2:0] code);
        case (code)
            OP_SLLV, OP_SRLV, OP_SRAV: amtSelFor = AMT_REGB;
            OP_LUI:                    amtSelFor = AMT_CONST16;
            default:                   amtSelFor = AMT_SHAMT;
        endcase
    endfunction

    function automatic logic dataSelFor(input logic [2:0] code);
        dataSelFor = (code == OP_LUI);
    endfunction

    function automatic logic [CMD_W-1:0] shiftCmdFor(input logic [2:0] code);
        case (code)
            OP_SRL, OP_SRLV: shiftCmdFor = CMD_SRL;
            OP_SRA, OP_SRAV: shiftCmdFor = CMD_SRA;
            default:         shiftCmdFor = CMD_SLEFT;
        endcase
    endfunction

    // Next-state and next-output decode; selects hold unless a new op is accepted
    always_comb begin
        stateNext    = state;
        opNext       = opLatched;
        amtSelNext   = amt_sel;
        dataSelNext  = data_sel;
        shiftCmdNext = CMD_NOP;
        busyNext     = 1'b0;
        doneNext     = 1'b0;
        regWrNext    = 1'b0;
        errNext      = 1'b0;

        if (flush) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == OP_ILLEGAL) begin
                            errNext = 1'b1;
                        end else begin
                            stateNext    = LOAD;
                            opNext       = op;
                            amtSelNext   = amtSelFor(op);
                            dataSelNext  = dataSelFor(op);
                            shiftCmdNext = CMD_LOAD;
                            busyNext     = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    stateNext    = SHIFT;
                    shiftCmdNext = shiftCmdFor(opLatched);
                    busyNext     = 1'b1;
                end
                SHIFT: begin
                    stateNext = WB;
                    busyNext  = 1'b1;
                    doneNext  = 1'b1;
                    regWrNext = 1'b1;
                end
                WB: begin
                    stateNext = IDLE;
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            opLatched <= OP_SLL;
            amt_sel   <= AMT_SHAMT;
            data_sel  <= 1'b0;
            shift_cmd <= CMD_NOP;
            busy      <= 1'b0;
            done      <= 1'b0;
            reg_wr    <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= stateNext;
            opLatched <= opNext;
            amt_sel   <= amtSelNext;
            data_sel  <= dataSelNext;
            shift_cmd <= shiftCmdNext;
            busy      <= busyNext;
            done      <= doneNext;
            reg_wr    <= regWrNext;
            err       <= errNext;
        end
    end

endmodule

// File: tb/tb_shift_unit_ctrl.sv
// Directed bench for shift_unit_ctrl: expected per-cycle output vectors are queued as
// stimulus is driven and popped one per clock.
module tb_shift_unit_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic       flush;
    logic [2:0] amt_sel;
    logic       data_sel;
    logic [2:0] shift_cmd;
    logic       busy;
    logic       done;
    logic       reg_wr;
    logic       err;

    int compared   = 0;
    int mismatched = 0;

    string      tagQ[$];
    logic [10:0] vecQ[$];

    logic [2:0] curAmt = 3'b000;
    logic       curDs  = 1'b0;

    shift_unit_ctrl #(.CMD_W(3), .SEL_W(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .flush    (flush),
        .amt_sel  (amt_sel),
        .data_sel (data_sel),
        .shift_cmd(shift_cmd),
        .busy     (busy),
        .done     (done),
        .reg_wr   (reg_wr),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Observed vector layout: {amt_sel, data_sel, shift_cmd, busy, done, reg_wr, err}
    function automatic logic [10:0] mk(input logic [2:0] a, input logic d, input logic [2:0] c,
                                       input logic b, input logic dn, input logic w, input logic e);
        return {a, d, c, b, dn, w, e};
    endfunction

    function automatic logic [10:0] observed();
        return {amt_sel, data_sel, shift_cmd, busy, done, reg_wr, err};
    endfunction

    task automatic pushExp(input string t, input logic [10:0] v);
        tagQ.push_back(t);
        vecQ.push_back(v);
    endtask

    task automatic pushOp(input logic [2:0] o, input string t);
        logic [2:0] a;
        logic       d;
        logic [2:0] c;
        case (o)
            3'b011, 3'b100, 3'b101: a = 3'b010;
            3'b110:                 a = 3'b100;
            default:                a = 3'b000;
        endcase
        d = (o == 3'b110);
        case (o)
            3'b001, 3'b100: c = 3'b011;
            3'b010, 3'b101: c = 3'b100;
            default:        c = 3'b010;
        endcase
        pushExp({t, "_load"},  mk(a, d, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0));
        pushExp({t, "_shift"}, mk(a, d, c,      1'b1, 1'b0, 1'b0, 1'b0));
        pushExp({t, "_wb"},    mk(a, d, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0));
        pushExp({t, "_idle"},  mk(a, d, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
        curAmt = a;
        curDs  = d;
    endtask

    task automatic stepCheck();
        string       t;
        logic [10:0] v;
        @(posedge clk);
        #1;
        compared++;
        if (vecQ.size() == 0) begin
            mismatched++;
            $error("FAIL scoreboard_empty observed=%b required=<entry>", observed());
        end else begin
            t = tagQ.pop_front();
            v = vecQ.pop_front();
            assert (observed() === v) else begin
                mismatched++;
                $error("FAIL %s observed=%b required=%b", t, observed(), v);
            end
        end
    endtask

    task automatic runOp(input logic [2:0] o, input string t);
        start = 1'b1;
        op    = o;
        pushOp(o, t);
        stepCheck();
        start = 1'b0;
        repeat (3) stepCheck();
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b1;
        op    = 3'b000;
        flush = 1'b0;

        // reset held with start asserted: everything stays zero
        repeat (3) pushExp("reset_hold", mk(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
        repeat (3) stepCheck();
        reset = 1'b1;

        // SLL picked up from the still-asserted start
        pushOp(3'b000, "sll");
        stepCheck();
        start = 1'b0;
        repeat (3) stepCheck();

        runOp(3'b101, "srav");
        runOp(3'b110, "lui");

        // illegal op: one-cycle err, selects hold LUI values
        start = 1'b1;
        op    = 3'b111;
        pushExp("illegal_err", mk(curAmt, curDs, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1));
        stepCheck();
        start = 1'b0;
        pushExp("illegal_clear", mk(curAmt, curDs, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
        stepCheck();

        // start held: issue every 4 cycles; op toggling mid-flight is ignored
        start = 1'b1;
        op    = 3'b001;
        pushOp(3'b001, "srl_a");
        stepCheck();
        op = 3'b101;
        stepCheck();
        op = 3'b111;
        stepCheck();
        op = 3'b001;
        stepCheck();
        pushOp(3'b001, "srl_b");
        repeat (3) stepCheck();
        start = 1'b0;
        stepCheck();

        // flush leaving SHIFT: no done/reg_wr
        start = 1'b1;
        op    = 3'b000;
        pushExp("fsh_load", mk(3'b000, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0));
        stepCheck();
        start = 1'b0;
        pushExp("fsh_shift", mk(3'b000, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0));
        stepCheck();
        flush = 1'b1;
        pushExp("fsh_flushed", mk(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
        stepCheck();
        flush = 1'b0;
        pushExp("fsh_nodone", mk(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
        stepCheck();
        curAmt = 3'b000;
        curDs  = 1'b0;

        // flush leaving LOAD (LUI): selects keep the loaded values
        start = 1'b1;
        op    = 3'b110;
        pushExp("fld_load", mk(3'b100, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0));
        stepCheck();
        start = 1'b0;
        flush = 1'b1;
        pushExp("fld_flushed", mk(3'b100, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
        stepCheck();
        curAmt = 3'b100;
        curDs  = 1'b1;

        // flush with start in IDLE: start dropped, no err even for illegal op
        start = 1'b1;
        op    = 3'b111;
        pushExp("fidle_illegal", mk(curAmt, curDs, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
        stepCheck();
        op = 3'b010;
        pushExp("fidle_sra", mk(curAmt, curDs, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
        stepCheck();
        start = 1'b0;
        flush = 1'b0;

        // async reset between edges while in LOAD
        start = 1'b1;
        op    = 3'b011;
        pushExp("ar_load", mk(3'b010, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0));
        stepCheck();
        start = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        compared++;
        assert (observed() === 11'b0) else begin
            mismatched++;
            $error("FAIL async_reset_clear observed=%b required=%b", observed(), 11'b0);
        end
        @(posedge clk);
        #1;
        compared++;
        assert (observed() === 11'b0) else begin
            mismatched++;
            $error("FAIL async_reset_held observed=%b required=%b", observed(), 11'b0);
        end
        reset = 1'b1;

        runOp(3'b010, "sra_post_reset");
        runOp(3'b100, "srlv");

        compared++;
        assert (vecQ.size() === 0) else begin
            mismatched++;
            $error("FAIL scoreboard_leftover observed=%0d required=0", vecQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
